// File: rtl/led_step_ctrl.sv
// Button debounce plus run/speed/direction control and step-pulse generation for the LED shifter.
// Build option DIR_KEY_EN: when defined, key_n[2] is debounced and each press toggles dir.
module led_step_ctrl #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int PERIOD0      = 50_000_000,
  parameter int PERIOD1      = 25_000_000,
  parameter int PERIOD2      = 12_500_000,
  parameter int PERIOD3      = 6_250_000,
  parameter int CNT_W        = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] key_n,
  output logic       step_tick,
  output logic       run,
  output logic [1:0] speed_sel,
  output logic       dir,
  output logic [2:0] key_press
);

`ifdef DIR_KEY_EN
  localparam int NK = 3;
`else
  localparam int NK = 2;
`endif

  localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  logic [NK-1:0]   sync1_r;
  logic [NK-1:0]   sync2_r;
  logic [NK-1:0]   deb_r;
  logic [NK-1:0]   deb_d_r;
  logic [NK-1:0]   press_r;
  logic [DB_W-1:0] db_cnt_r [NK];

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [CNT_W-1:0] period_last_s;
  logic             tick_r;
  logic             tick_nxt_s;
  logic             run_r;
  logic             run_nxt_s;
  logic [1:0]       speed_r;
  logic [1:0]       speed_nxt_s;

  // Key path: 2-flop synchroniser, per-key debounce counter, falling-edge press detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= {NK{1'b1}};
      sync2_r <= {NK{1'b1}};
      deb_r   <= {NK{1'b1}};
      deb_d_r <= {NK{1'b1}};
      press_r <= {NK{1'b0}};
      for (int k = 0; k < NK; k++) begin
        db_cnt_r[k] <= {DB_W{1'b0}};
      end
    end else begin
      sync1_r <= key_n[NK-1:0];
      sync2_r <= sync1_r;
      deb_d_r <= deb_r;
      press_r <= deb_d_r & ~deb_r;
      for (int k = 0; k < NK; k++) begin
        if (sync2_r[k] == deb_r[k]) begin
          db_cnt_r[k] <= {DB_W{1'b0}};
        end else if (db_cnt_r[k] == DB_LAST) begin
          deb_r[k]    <= sync2_r[k];
          db_cnt_r[k] <= {DB_W{1'b0}};
        end else begin
          db_cnt_r[k] <= db_cnt_r[k] + DB_W'(1);
        end
      end
    end
  end

  // Terminal-count select and control next state; a speed press or a pause beats terminal count.
  always_comb begin
    period_last_s = CNT_W'(PERIOD0 - 1);
    case (speed_r)
      2'd0:    period_last_s = CNT_W'(PERIOD0 - 1);
      2'd1:    period_last_s = CNT_W'(PERIOD1 - 1);
      2'd2:    period_last_s = CNT_W'(PERIOD2 - 1);
      2'd3:    period_last_s = CNT_W'(PERIOD3 - 1);
      default: period_last_s = CNT_W'(PERIOD0 - 1);
    endcase
    run_nxt_s   = run_r ^ press_r[0];
    speed_nxt_s = speed_r + {1'b0, press_r[1]};
    cnt_nxt_s   = cnt_r;
    tick_nxt_s  = 1'b0;
    if (press_r[1]) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (run_r && !press_r[0]) begin
      if (cnt_r == period_last_s) begin
        cnt_nxt_s  = {CNT_W{1'b0}};
        tick_nxt_s = 1'b1;
      end else begin
        cnt_nxt_s = cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Control and period-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= {CNT_W{1'b0}};
      tick_r  <= 1'b0;
      run_r   <= 1'b1;
      speed_r <= 2'd0;
    end else begin
      cnt_r   <= cnt_nxt_s;
      tick_r  <= tick_nxt_s;
      run_r   <= run_nxt_s;
      speed_r <= speed_nxt_s;
    end
  end

`ifdef DIR_KEY_EN
  logic dir_r;

  // Direction flips on each accepted key[2] press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_r <= 1'b0;
    end else begin
      dir_r <= dir_r ^ press_r[2];
    end
  end

  assign dir       = dir_r;
  assign key_press = press_r;
`else
  logic unused_key2;
  assign unused_key2 = key_n[2];
  assign dir         = 1'b0;
  assign key_press   = {1'b0, press_r};
`endif

  assign step_tick = tick_r;
  assign run       = run_r;
  assign speed_sel = speed_r;

endmodule

// File: tb/tb_led_step_ctrl.sv
// Directed self-checking bench for led_step_ctrl with shortened debounce and step periods.
module tb_led_step_ctrl;

  logic       clk;
  logic       rst_n;
  logic [2:0] key_n;
  logic       step_tick;
  logic       run;
  logic [1:0] speed_sel;
  logic       dir;
  logic [2:0] key_press;

  int n_checks;
  int n_errors;
  int cyc;
  int ticks[$];
  int pcount[3];
  int last_press[3];
  int wide_tick;
  int wide_press;
  logic       prev_tick;
  logic [2:0] prev_press;

  led_step_ctrl #(
    .DEBOUNCE_CYC(8),
    .PERIOD0(10),
    .PERIOD1(6),
    .PERIOD2(4),
    .PERIOD3(2),
    .CNT_W(26)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_n(key_n),
    .step_tick(step_tick),
    .run(run),
    .speed_sel(speed_sel),
    .dir(dir),
    .key_press(key_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n cycles, sampling 1 ns after each rising edge and logging ticks and presses.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (step_tick) begin
        ticks.push_back(cyc);
        if (prev_tick) wide_tick++;
      end
      prev_tick = step_tick;
      for (int k = 0; k < 3; k++) begin
        if (key_press[k]) begin
          pcount[k]++;
          last_press[k] = cyc;
          if (prev_press[k]) wide_press++;
        end
      end
      prev_press = key_press;
    end
  endtask

  task automatic press_key(input int k, input int low_cycles);
    key_n[k] = 1'b0;
    tick(low_cycles);
    key_n[k] = 1'b1;
  endtask

  task automatic wait_tick(output int e);
    int found;
    found = 0;
    e = -1;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (step_tick) begin
        found = 1;
        e = cyc;
        break;
      end
    end
    chk_eq("wait_tick_timeout", found, 1);
  endtask

  function automatic int first_tick_after(input int c);
    foreach (ticks[i]) begin
      if (ticks[i] > c) return ticks[i];
    end
    return -1;
  endfunction

  function automatic int count_ticks(input int a, input int b);
    int n;
    n = 0;
    foreach (ticks[i]) begin
      if (ticks[i] > a && ticks[i] <= b) n++;
    end
    return n;
  endfunction

  initial begin
    int r0, r1, e, p, rp, t1, t2, st;
    int exp_speed[4];
    int exp_per[4];
    exp_speed = '{1, 2, 3, 0};
    exp_per   = '{6, 4, 2, 10};
    n_checks = 0; n_errors = 0; cyc = 0;
    wide_tick = 0; wide_press = 0;
    prev_tick = 1'b0; prev_press = 3'b000;
    for (int k = 0; k < 3; k++) begin
      pcount[k] = 0;
      last_press[k] = -1;
    end
    key_n = 3'b111;
    rst_n = 1'b0;
    tick(3);
    chk_eq("rst_run", run, 1);
    chk_eq("rst_speed", speed_sel, 0);
    chk_eq("rst_dir", dir, 0);
    chk_eq("rst_tick", step_tick, 0);
    chk_eq("rst_press", key_press, 0);

    rst_n = 1'b1;
    r0 = cyc;
    tick(35);
    chk_eq("first_tick", first_tick_after(r0) - r0, 10);
    chk_eq("tick_count35", count_ticks(r0, r0 + 35), 3);
    chk_eq("tick_spacing0", first_tick_after(first_tick_after(r0)) - first_tick_after(r0), 10);

    press_key(0, 5);
    tick(20);
    chk_eq("glitch_no_press", pcount[0], 0);
    chk_eq("glitch_run", run, 1);

    wait_tick(e);
    press_key(0, 20);
    chk_eq("press0_latency", last_press[0] - e, 11);
    tick(20);
    chk_eq("pause_press_once", pcount[0], 1);
    chk_eq("paused_run", run, 0);
    chk_eq("paused_no_tick", count_ticks(last_press[0], cyc), 0);

    press_key(0, 20);
    rp = last_press[0] + 1;
    tick(15);
    chk_eq("resume_press", pcount[0], 2);
    chk_eq("resume_run", run, 1);
    chk_eq("resume_remaining", first_tick_after(rp) - rp, 9);

    for (int i = 0; i < 4; i++) begin
      press_key(1, 12);
      tick(25);
      p = last_press[1];
      chk_eq("speed_sel", speed_sel, exp_speed[i]);
      t1 = first_tick_after(p);
      t2 = first_tick_after(t1);
      chk_eq("speed_first_tick", t1 - (p + 1), exp_per[i]);
      chk_eq("speed_spacing", t2 - t1, exp_per[i]);
    end

    wait_tick(e);
    tick(8);
    st = cyc;
    press_key(1, 12);
    tick(15);
    p = last_press[1];
    chk_eq("press1_latency", p - st, 11);
    chk_eq("align_no_tick", count_ticks(p, p + 1), 0);
    chk_eq("align_restart", first_tick_after(p) - p, 7);
    chk_eq("align_speed", speed_sel, 1);

    press_key(2, 20);
    tick(15);
`ifdef DIR_KEY_EN
    chk_eq("dir_first", dir, 1);
    chk_eq("dir_press_cnt1", pcount[2], 1);
`else
    chk_eq("dir_first_off", dir, 0);
    chk_eq("dir_press_cnt1_off", pcount[2], 0);
`endif
    press_key(2, 20);
    tick(15);
    chk_eq("dir_second", dir, 0);
`ifdef DIR_KEY_EN
    chk_eq("dir_press_cnt2", pcount[2], 2);
`else
    chk_eq("dir_press_cnt2_off", pcount[2], 0);
`endif

    press_key(1, 12);
    tick(15);
    chk_eq("pre_rst_speed", speed_sel, 2);
    press_key(0, 20);
    tick(15);
    chk_eq("pre_rst_run", run, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("midrst_run", run, 1);
    chk_eq("midrst_speed", speed_sel, 0);
    chk_eq("midrst_tick", step_tick, 0);
    chk_eq("midrst_press", key_press, 0);
    tick(3);
    rst_n = 1'b1;
    r1 = cyc;
    tick(25);
    chk_eq("rst_quiet", count_ticks(r1 - 4, r1), 0);
    chk_eq("post_rst_first_tick", first_tick_after(r1) - r1, 10);

    chk_eq("tick_width", wide_tick, 0);
    chk_eq("press_width", wide_press, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
